// File: rtl/rep_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rep_seq_pkg
// Description : Shared defaults, helper function and types for the
//               rep_seq_ctrl response sequencer.
// Contents    : REQ_LEN_D / GAP_D / ACK_LEN_D / CNT_W_D default constants,
//               clog2_min1() width helper, match_cnt_t default counter type.
// Revision    : 1.0 - initial release
// ============================================================================
package rep_seq_pkg;

  localparam int REQ_LEN_D = 2;
  localparam int GAP_D     = 2;
  localparam int ACK_LEN_D = 2;
  localparam int CNT_W_D   = 8;

  // Match counter type at the default width.
  typedef logic [CNT_W_D-1:0] match_cnt_t;

  // ceil(log2(n)), but never below 1, so a vector sized from it is never empty.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage : rep_seq_pkg
`default_nettype wire

// File: rtl/rep_run_det.sv
`default_nettype none
// ============================================================================
// Module      : rep_run_det
// Description : Consecutive-request run counter and match detector.
//               A match is flagged in the cycle that completes a run of
//               REQ_LEN qualified requests; longer runs match every cycle.
// Ports       : clk   - clock
//               rst   - asynchronous active-high reset
//               en    - request qualifier (0 breaks the run)
//               clr   - synchronous flush (breaks the run, suppresses match)
//               req   - request line
//               match - combinational match pulse
// Revision    : 1.0 - initial release
// ============================================================================
module rep_run_det
  import rep_seq_pkg::*;
#(
  parameter int REQ_LEN = REQ_LEN_D
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic req,
  output logic match
);

  localparam int RUN_W = $clog2(REQ_LEN) + 1;
  localparam logic [RUN_W-1:0] C_RUN_MAX = RUN_W'(REQ_LEN - 1);

  logic [RUN_W-1:0] r_run_cnt;
  logic             w_qual;
  logic             w_at_max;

  assign w_qual   = req & en & ~clr;
  assign w_at_max = (r_run_cnt == C_RUN_MAX);
  assign match    = w_qual & w_at_max;

  // r_run_cnt holds the number of qualified cycles before the current one;
  // saturating at REQ_LEN-1 lets a long run keep matching each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cnt <= '0;
    end else if (!w_qual) begin
      r_run_cnt <= '0;
    end else if (!w_at_max) begin
      r_run_cnt <= r_run_cnt + RUN_W'(1);
    end
  end

endmodule : rep_run_det
`default_nettype wire

// File: rtl/rep_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rep_seq_ctrl
// Description : Response sequencer for "req[*REQ_LEN] |-> ##GAP ack[*ACK_LEN]".
//               Each match schedules an ACK_LEN-cycle ack starting GAP cycles
//               later; overlapping windows merge into one contiguous pulse.
// Ports       : clk       - clock
//               rst       - asynchronous active-high reset
//               en        - request qualifier; pending acks keep draining
//               clr       - synchronous flush of run counter and ack pipeline
//               req       - request line
//               ack       - acknowledge (decoded purely from flops)
//               match     - combinational pulse on run completion
//               busy      - any match still pending in the pipeline
//               match_cnt - saturating match counter (kept across clr)
// Options     : REP_SEQ_ASSERT_EN - embeds protocol assertion, overlap cover
//               and counter no-wrap check.
// Revision    : 1.0 - initial release
// ============================================================================
module rep_seq_ctrl
  import rep_seq_pkg::*;
#(
  parameter int REQ_LEN = REQ_LEN_D,
  parameter int GAP     = GAP_D,
  parameter int ACK_LEN = ACK_LEN_D,
  parameter int CNT_W   = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             req,
  output logic             ack,
  output logic             match,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt
);

  if (REQ_LEN < 1 || GAP < 1 || ACK_LEN < 1) begin : g_bad_param
    $error("rep_seq_ctrl: REQ_LEN, GAP and ACK_LEN must all be >= 1");
  end

  localparam int DEPTH = GAP + ACK_LEN - 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic             w_match;
  logic [DEPTH-1:0] r_pipe;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  rep_run_det #(
    .REQ_LEN (REQ_LEN)
  ) u_run_det (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .req   (req),
    .match (w_match)
  );

  // r_pipe[i] set means a match happened i+1 cycles ago.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= '0;
    end else if (clr) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | DEPTH'(w_match);
    end
  end

  assign w_cnt_next = (w_match && (r_match_cnt != C_CNT_MAX)) ?
                      (r_match_cnt + CNT_W'(1)) : r_match_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_cnt <= '0;
    end else begin
      r_match_cnt <= w_cnt_next;
    end
  end

  // Ack window spans matches GAP..GAP+ACK_LEN-1 cycles old.
  assign ack       = |r_pipe[DEPTH-1:GAP-1];
  assign busy      = |r_pipe;
  assign match     = w_match;
  assign match_cnt = r_match_cnt;

`ifdef REP_SEQ_ASSERT_EN
  property p_handshake;
    @(posedge clk) disable iff (rst || clr)
      (req && en)[*REQ_LEN] |-> ##GAP ack[*ACK_LEN];
  endproperty

  a_handshake : assert property (p_handshake)
    $info("rep_seq_ctrl: handshake satisfied at %0t", $time);
  else
    $error("rep_seq_ctrl: handshake violated at %0t", $time);

  c_overlap : cover property (@(posedge clk) disable iff (rst) w_match ##1 w_match);

  always_comb begin
    if (!rst) begin
      a_no_wrap : assert (w_cnt_next >= r_match_cnt)
        else $error("rep_seq_ctrl: match_cnt wrapped at %0t", $time);
    end
  end
`else
  // Assertion block not compiled in this build.
`endif

endmodule : rep_seq_ctrl
`default_nettype wire

// File: tb/tb_rep_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rep_seq_ctrl
// Description : Self-checking bench for rep_seq_ctrl. Two instances share the
//               stimulus: default parameters, and CNT_W=2 for saturation.
//               Expected match/ack/busy per cycle are queued as each cycle is
//               driven and popped when the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rep_seq_ctrl;
  import rep_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, clr, req;
  logic       ack, match, busy;
  match_cnt_t match_cnt;
  logic       ack2, match2, busy2;
  logic [1:0] match_cnt2;

  int checks   = 0;
  int failures = 0;
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  rep_seq_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req),
    .ack(ack), .match(match), .busy(busy), .match_cnt(match_cnt)
  );

  rep_seq_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req),
    .ack(ack2), .match(match2), .busy(busy2), .match_cnt(match_cnt2)
  );

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Leaves reset released mid low phase; next posedge is cycle 0.
  task automatic do_reset();
    rst = 1'b1; req = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle, queue its expectation, sample at the falling edge.
  task automatic cycle(input logic r, input logic e, input logic k,
                       input logic [2:0] exp_v,
                       output logic [2:0] obs, output logic [2:0] exq);
    @(posedge clk);
    #1;
    req = r; en = e; clr = k;
    sb.push_back(exp_v);
    @(negedge clk);
    obs = {match, ack, busy};
    exq = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; en = 1'b1; clr = 1'b0;
    #2;
    checks++;
    if ({match, ack, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got m/a/b=%b want=000", {match, ack, busy});
    end
    @(posedge clk); #1;
    checks++;
    if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", match_cnt, match_cnt2);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rq, mm, am, bm;
    logic [2:0] o, x;
    do_reset();
    rq = rng(2, 3); mm = rng(3, 3); am = rng(5, 6); bm = rng(4, 6);
    for (int c = 0; c < 10; c++) begin
      cycle(rq[c], 1'b1, 1'b0, {mm[c], am[c], bm[c]}, o, x);
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL basic cyc=%0d m/a/b got=%b want=%b", c, o, x);
      end
    end
    checks++;
    if (match_cnt !== 8'd1 || match_cnt2 !== 2'd1) begin
      failures++;
      $display("FAIL basic_cnt got=%0d/%0d want=1/1", match_cnt, match_cnt2);
    end
  endtask

  task automatic test_short();
    logic [31:0] rq;
    logic [2:0] o, x;
    do_reset();
    rq = rng(2, 2);
    for (int c = 0; c < 8; c++) begin
      cycle(rq[c], 1'b1, 1'b0, 3'b000, o, x);
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL short cyc=%0d m/a/b got=%b want=%b", c, o, x);
      end
    end
    checks++;
    if (match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL short_cnt got=%0d want=0", match_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rq, mm, am, bm;
    logic [2:0] o, x;
    do_reset();
    rq = rng(2, 5); mm = rng(3, 5); am = rng(5, 8); bm = rng(4, 8);
    for (int c = 0; c < 12; c++) begin
      cycle(rq[c], 1'b1, 1'b0, {mm[c], am[c], bm[c]}, o, x);
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL overlap cyc=%0d m/a/b got=%b want=%b", c, o, x);
      end
    end
    checks++;
    if (match_cnt !== 8'd3 || match_cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL overlap_cnt got=%0d/%0d want=3/3", match_cnt, match_cnt2);
    end
  endtask

  task automatic test_clr();
    logic [31:0] rq, cm, mm, bm;
    logic [2:0] o, x;
    do_reset();
    rq = rng(2, 3); cm = rng(4, 4); mm = rng(3, 3); bm = rng(4, 4);
    for (int c = 0; c < 10; c++) begin
      cycle(rq[c], 1'b1, cm[c], {mm[c], 1'b0, bm[c]}, o, x);
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL clr_mid cyc=%0d m/a/b got=%b want=%b", c, o, x);
      end
    end
    checks++;
    if (match_cnt !== 8'd1) begin
      failures++;
      $display("FAIL clr_mid_cnt got=%0d want=1", match_cnt);
    end
  endtask

  task automatic test_clr_req();
    logic [31:0] rq, cm;
    logic [2:0] o, x;
    do_reset();
    rq = rng(2, 3); cm = rng(3, 3);
    for (int c = 0; c < 9; c++) begin
      cycle(rq[c], 1'b1, cm[c], 3'b000, o, x);
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL clr_req cyc=%0d m/a/b got=%b want=%b", c, o, x);
      end
    end
    checks++;
    if (match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clr_req_cnt got=%0d want=0", match_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rq, mm, am, bm;
    logic [2:0] o, x;
    do_reset();
    rq = rng(2, 3); mm = rng(3, 3); am = rng(5, 6); bm = rng(4, 6);
    for (int c = 0; c < 6; c++) begin
      cycle(rq[c], 1'b1, 1'b0, {mm[c], am[c], bm[c]}, o, x);
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL areset_pre cyc=%0d m/a/b got=%b want=%b", c, o, x);
      end
    end
    checks++;
    if (match_cnt !== 8'd1) begin
      failures++;
      $display("FAIL areset_pre_cnt got=%0d want=1", match_cnt);
    end
    // Between edges 5 and 6, far from any clock edge.
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ack, busy} !== 2'b00 || match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL areset_now got a/b=%b cnt=%0d want a/b=00 cnt=0", {ack, busy}, match_cnt);
    end
    #1 rst = 1'b0;
    for (int c = 6; c < 10; c++) begin
      cycle(1'b0, 1'b1, 1'b0, 3'b000, o, x);
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL areset_post cyc=%0d m/a/b got=%b want=%b", c, o, x);
      end
    end
    checks++;
    if (match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL areset_post_cnt got=%0d want=0", match_cnt);
    end
  endtask

  task automatic test_sat_en();
    logic [31:0] rq, enm, mm, am, bm;
    logic [2:0] o, x;
    do_reset();
    rq  = rng(2, 3) | rng(6, 7) | rng(10, 11) | rng(14, 15) | rng(18, 21);
    enm = rng(20, 21);
    mm  = rng(3, 3) | rng(7, 7) | rng(11, 11) | rng(15, 15) | rng(19, 19);
    am  = rng(5, 6) | rng(9, 10) | rng(13, 14) | rng(17, 18) | rng(21, 22);
    bm  = rng(4, 6) | rng(8, 10) | rng(12, 14) | rng(16, 18) | rng(20, 22);
    for (int c = 0; c < 25; c++) begin
      cycle(rq[c], ~enm[c], 1'b0, {mm[c], am[c], bm[c]}, o, x);
      checks++;
      if (o !== x) begin
        failures++;
        $display("FAIL sat_en cyc=%0d m/a/b got=%b want=%b", c, o, x);
      end
      checks++;
      if ({match2, ack2, busy2} !== x) begin
        failures++;
        $display("FAIL sat_en_w2 cyc=%0d m/a/b got=%b want=%b", c, {match2, ack2, busy2}, x);
      end
    end
    checks++;
    if (match_cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL sat_cnt_w2 got=%0d want=3", match_cnt2);
    end
    checks++;
    if (match_cnt !== 8'd5) begin
      failures++;
      $display("FAIL sat_cnt_w8 got=%0d want=5", match_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; en = 1'b1; clr = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_back_to_back();
    test_clr();
    test_clr_req();
    test_async_reset();
    test_sat_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rep_seq_ctrl
`default_nettype wire

// File: doc/rep_seq_ctrl.md
Name: rep_seq_ctrl

Overview:
- Response sequencer for the consecutive-repetition handshake "req[*REQ_LEN] |-> ##GAP ack[*ACK_LEN]".
- Watches a request line and drives the acknowledge line so that the protocol property always holds, including overlapping and retriggered requests.
- Sits between a requester and the resource it is asking for.
- Also provides a match pulse, a busy flag and a saturating match counter for software or scoreboard visibility.

Parameters:
- REQ_LEN, 2, consecutive req-high cycles that form one match; legal range >=1.
- GAP, 2, cycles from the match cycle to the first ack cycle; legal range >=1.
- ACK_LEN, 2, consecutive ack-high cycles per match; legal range >=1.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  when 0, req is treated as 0; the ack pipeline keeps draining.
- clr  in  1  synchronous flush of the run counter and ack pipeline; match_cnt is kept.
- req  in  1  request line, sampled on posedge.
- ack  out  1  acknowledge line.
- match  out  1  combinational pulse; high in the cycle that completes a REQ_LEN run.
- busy  out  1  high while any match is still pending in the pipeline.
- match_cnt  out  CNT_W  number of matches, saturating.

Behaviour:
- Reset (async, rst=1):
  - run_cnt, pipe and match_cnt go to 0.
  - ack=0 and busy=0 immediately, without waiting for a clock edge.
  - A reset in mid-sequence discards all pending acks.
- run_cnt (width clog2(REQ_LEN)+1):
  - Counts prior consecutive qualified-req cycles; qualified req = req & en & ~clr.
  - Incremented when qualified req=1, saturating at REQ_LEN-1.
  - Cleared to 0 when qualified req=0.
- match = qualified req & (run_cnt == REQ_LEN-1). For REQ_LEN=1, match equals qualified req.
- Overlap: a run of L>=REQ_LEN cycles produces L-REQ_LEN+1 back-to-back matches, one per cycle.
- pipe: shift register of depth D = GAP+ACK_LEN-1.
  - pipe[0] <= match; pipe[i] <= pipe[i-1].
  - pipe[i] means "match occurred i+1 cycles ago".
- ack = OR of pipe[GAP-1] through pipe[D-1], decoded from flops with no combinational path from req.
  - A match at cycle t gives ack=1 for cycles t+GAP through t+GAP+ACK_LEN-1.
  - Overlapping windows merge into one contiguous ack pulse.
- busy = OR of all pipe bits. It covers the GAP wait and the ack window.
- match_cnt increments on each match and holds at 2^CNT_W-1.
- clr=1 at cycle t:
  - pipe and run_cnt clear at the edge; ack=0 from t+1.
  - match is forced to 0 in cycle t.
- en=0: the run breaks (run_cnt clears), while already-scheduled acks still complete.
- Simultaneous clr and req=1: clr wins and no match is produced.
- Parameter checks: elaboration-time error if REQ_LEN, GAP or ACK_LEN is less than 1.

Optional Feature:
- Macro REP_SEQ_ASSERT_EN.
- When defined, the block embeds these checks:
  - Concurrent assertion, disabled iff (rst || clr): @(posedge clk) (req&&en)[*REQ_LEN] |-> ##GAP ack[*ACK_LEN]. Pass action is $info with $time; fail action is $error.
  - Cover property on two overlapping matches.
  - Immediate assertion that match_cnt never wraps.
- When undefined, no assertion code is compiled and the RTL is identical otherwise.

Decomposition:
- Package rep_seq_pkg holds:
  - Default constants REQ_LEN_D=2, GAP_D=2, ACK_LEN_D=2, CNT_W_D=8.
  - Function clog2_min1.
  - typedef match_cnt_t.
- One natural sub-module, rep_run_det: the run_cnt plus match detector, parameterised by REQ_LEN.
- The top level holds the pipe, ack/busy decode, counter and assertion block.

Test Plan (defaults, cycles numbered by posedge, en=1, clr=0):
- Basic pass: req=1 at cycles 2-3, otherwise 0 -> match at 3; ack=1 at cycles 5-6 only; busy=1 at 4-6; match_cnt=1.
- Short request: req=1 at cycle 2 only -> no match; ack stays 0; match_cnt=0.
- Overlap: req=1 at cycles 2-5 -> matches at 3, 4, 5; ack=1 at 5-8 as one contiguous pulse; match_cnt=3.
- clr mid-sequence: req=1 at 2-3, clr=1 at cycle 4 -> ack stays 0 throughout; busy=0 from 5; match_cnt=1.
- Async reset: req=1 at 2-3, rst asserted between edges 5 and 6 -> ack drops immediately on rst rise and stays 0 after release; match_cnt=0.
- Saturation and en: with CNT_W=2, drive 5 separate 2-cycle req runs -> match_cnt holds at 3. Then en=0 during req=1 at 20-21 -> no match and no ack.
